// File: rtl/fpalu_pkg.sv
// Shared FPALU definitions: FP29i and FP16 field widths, biases and constants.
package fpalu_pkg;

    // FP29i: sign, 6-bit exponent, 22-bit left-aligned mantissa (may be denormal).
    localparam int unsigned AL_EXPSIZE = 6;
    localparam int unsigned AL_MANSIZE = 22;
    localparam int unsigned AL_EXPBIAS = 31;

    // IEEE FP16.
    localparam int unsigned ML_EXPBIAS    = 15;
    localparam int unsigned OUT_EXPBIAS   = ML_EXPBIAS;
    localparam int unsigned FP16_EXPSIZE  = 5;
    localparam int unsigned FP16_FRACSIZE = 10;
    localparam int unsigned FP16_WIDTH    = 16;

    // Magnitude bits of FP16 infinity (sign is supplied separately).
    localparam logic [14:0] FP16_INF_MAG = 15'h7C00;

    // Aligned word handed from the align stage to round/pack.
    typedef struct packed {
        logic                     sgn;
        logic                     zero;    // input mantissa was zero
        logic                     inf;     // exponent already beyond FP16 range
        logic                     tiny;    // result was shifted into the subnormal range
        logic [FP16_EXPSIZE-1:0]  efield;  // biased FP16 exponent, 0 when subnormal
        logic [FP16_FRACSIZE-1:0] frac;    // kept fraction bits below the hidden bit
        logic                     guard;
        logic                     sticky;
    } align_t;

endpackage

// File: rtl/count_lead_zero.sv
// Leading-zero counter: zero bits above the most significant set bit; all-zero gives Width.
module count_lead_zero #(
    parameter int unsigned Width    = 22,
    parameter int unsigned CntWidth = $clog2(Width + 1)
) (
    input  logic [Width-1:0]    din_i,
    output logic [CntWidth-1:0] cnt_o
);

    // Scan upward so the last hit is the highest set bit.
    always_comb begin
        cnt_o = CntWidth'(Width);
        for (int i = 0; i < Width; i++) begin
            if (din_i[i]) begin
                cnt_o = CntWidth'(Width - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp16_round_pack.sv
// Round-to-nearest-even, FP16 packing and per-word exception flags.
module fp16_round_pack
    import fpalu_pkg::*;
(
    input  align_t                  word_i,
    output logic [FP16_WIDTH-1:0]   fp16_o,
    output logic                    ovf_o,
    output logic                    unf_o,
    output logic                    inx_o
);

    logic        rup;
    logic [14:0] mag;
    logic        ovf;
    logic        inx;

    // Fraction carry ripples into the exponent field, so subnormal->normal and
    // 30->31 (infinity) fall out of the same add.
    always_comb begin
        rup    = word_i.guard & (word_i.sticky | word_i.frac[0]);
        mag    = {word_i.efield, word_i.frac} + 15'(rup);
        ovf    = word_i.inf | (mag[14:10] == 5'h1F);
        inx    = word_i.guard | word_i.sticky | ovf;
        fp16_o = {word_i.sgn, mag};
        ovf_o  = 1'b0;
        unf_o  = 1'b0;
        inx_o  = 1'b0;
        if (word_i.zero) begin
            fp16_o = {word_i.sgn, 15'h0};
        end else begin
            if (ovf) begin
                fp16_o = {word_i.sgn, FP16_INF_MAG};
            end
            ovf_o = ovf;
            inx_o = inx;
            unf_o = word_i.tiny & inx;
        end
    end

endmodule

// File: rtl/fp29i_to_fp16.sv
// FP29i -> IEEE FP16 output converter: normalise, align, round/pack in a 3-stage
// pipeline with a single global stall and sticky exception flags.
module fp29i_to_fp16
    import fpalu_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sgn,
    input  logic [AL_EXPSIZE-1:0]   in_exp,
    input  logic [AL_MANSIZE-1:0]   in_man_dn,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [FP16_WIDTH-1:0]   out_fp16,
    input  logic                    clr_flags,
    output logic                    flag_ovf,
    output logic                    flag_unf,
    output logic                    flag_inx
);

    localparam int unsigned ExpWidth = 8;
    localparam int unsigned LzWidth  = $clog2(AL_MANSIZE + 1);
    localparam int unsigned GuardBit = AL_MANSIZE - 2 - FP16_FRACSIZE;
    localparam logic signed [ExpWidth-1:0] ExpDiff  = ExpWidth'(AL_EXPBIAS - OUT_EXPBIAS);
    localparam logic signed [ExpWidth-1:0] MaxShift = ExpWidth'(AL_MANSIZE + 1);

    logic en;

    // S1 state: normalised mantissa and unbiased-adjusted exponent.
    logic                        s1_valid_q;
    logic                        s1_sgn_q;
    logic                        s1_zero_q;
    logic [AL_MANSIZE-1:0]       s1_man_q, s1_man_d;
    logic signed [ExpWidth-1:0]  s1_exp_q, s1_exp_d;
    logic [LzWidth-1:0]          lz;

    // S2 state.
    logic                        s2_valid_q;
    align_t                      s2_q, s2_d;
    logic signed [ExpWidth-1:0]  e16;
    logic signed [ExpWidth-1:0]  d_full;
    logic [4:0]                  d;
    logic [AL_MANSIZE-1:0]       m_aligned;
    logic [AL_MANSIZE-1:0]       lost_mask;
    logic                        unused_hidden;

    // S3 / output state.
    logic                        out_valid_q;
    logic [FP16_WIDTH-1:0]       out_fp16_q;
    logic                        word_ovf_q, word_unf_q, word_inx_q;
    logic [FP16_WIDTH-1:0]       rp_fp16;
    logic                        rp_ovf, rp_unf, rp_inx;

    logic flag_ovf_q, flag_ovf_d;
    logic flag_unf_q, flag_unf_d;
    logic flag_inx_q, flag_inx_d;

    assign en       = ~out_valid_q | out_ready;
    assign in_ready = en;

    count_lead_zero #(
        .Width    (AL_MANSIZE),
        .CntWidth (LzWidth)
    ) u_clz (
        .din_i (in_man_dn),
        .cnt_o (lz)
    );

    // S1: shift the leading one to the top and compensate the exponent.
    always_comb begin
        s1_man_d = in_man_dn << lz;
        s1_exp_d = $signed(ExpWidth'(in_exp)) - $signed(ExpWidth'(lz));
    end

    // S2: rebias to FP16, denormalise below the normal range and collect round bits.
    always_comb begin
        e16    = s1_exp_q - ExpDiff;
        d_full = 8'sd1 - e16;
        if (e16 >= 8'sd1) begin
            d = 5'd0;
        end else if (d_full > MaxShift) begin
            d = MaxShift[4:0];
        end else begin
            d = d_full[4:0];
        end
        m_aligned = s1_man_q >> d;
        // A shift past the full width leaves the mask all ones: everything is sticky.
        lost_mask = ~({AL_MANSIZE{1'b1}} << d);

        s2_d.sgn    = s1_sgn_q;
        s2_d.zero   = s1_zero_q;
        s2_d.inf    = (e16 >= 8'sd31);
        s2_d.tiny   = (d != 5'd0);
        s2_d.efield = (d == 5'd0) ? e16[FP16_EXPSIZE-1:0] : '0;
        s2_d.frac   = m_aligned[GuardBit+FP16_FRACSIZE:GuardBit+1];
        s2_d.guard  = m_aligned[GuardBit];
        s2_d.sticky = (|(s1_man_q & lost_mask)) | (|m_aligned[GuardBit-1:0]);
    end

    // The hidden bit is implied by efield and never stored.
    assign unused_hidden = m_aligned[AL_MANSIZE-1];

    fp16_round_pack u_round_pack (
        .word_i (s2_q),
        .fp16_o (rp_fp16),
        .ovf_o  (rp_ovf),
        .unf_o  (rp_unf),
        .inx_o  (rp_inx)
    );

    // Pipeline registers: all stages advance together on en, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_sgn_q    <= 1'b0;
            s1_zero_q   <= 1'b0;
            s1_man_q    <= '0;
            s1_exp_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_q        <= '0;
            out_valid_q <= 1'b0;
            out_fp16_q  <= '0;
            word_ovf_q  <= 1'b0;
            word_unf_q  <= 1'b0;
            word_inx_q  <= 1'b0;
        end else if (en) begin
            s1_valid_q  <= in_valid;
            s1_sgn_q    <= in_sgn;
            s1_zero_q   <= (in_man_dn == '0);
            s1_man_q    <= s1_man_d;
            s1_exp_q    <= s1_exp_d;
            s2_valid_q  <= s1_valid_q;
            s2_q        <= s2_d;
            out_valid_q <= s2_valid_q;
            out_fp16_q  <= rp_fp16;
            word_ovf_q  <= rp_ovf;
            word_unf_q  <= rp_unf;
            word_inx_q  <= rp_inx;
        end
    end

    // Sticky flags: a word leaving the pipe sets, clr_flags clears, set wins.
    always_comb begin
        flag_ovf_d = clr_flags ? 1'b0 : flag_ovf_q;
        flag_unf_d = clr_flags ? 1'b0 : flag_unf_q;
        flag_inx_d = clr_flags ? 1'b0 : flag_inx_q;
        if (out_valid_q && out_ready) begin
            flag_ovf_d = flag_ovf_d | word_ovf_q;
            flag_unf_d = flag_unf_d | word_unf_q;
            flag_inx_d = flag_inx_d | word_inx_q;
        end
    end

    // Flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_ovf_q <= 1'b0;
            flag_unf_q <= 1'b0;
            flag_inx_q <= 1'b0;
        end else begin
            flag_ovf_q <= flag_ovf_d;
            flag_unf_q <= flag_unf_d;
            flag_inx_q <= flag_inx_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_fp16  = out_fp16_q;
    assign flag_ovf  = flag_ovf_q;
    assign flag_unf  = flag_unf_q;
    assign flag_inx  = flag_inx_q;

endmodule
